// File: rtl/frv_alu_arb.sv
// ----------------------------------------------------------------------------
// frv_alu_arb
//
// Shares the single execute-stage ALU between two requesters:
//   port A - pipeline execute stage, normal priority owner
//   port B - auxiliary multi-cycle unit (crypto / bitmanip sequencer)
// One operation is granted per cycle. The compact 4-bit opcode of the winner
// is decoded into the ALU one-hot op lines, and the ALU result is captured
// into a per-requester response register one cycle after the grant.
// B is protected against starvation and may hold the ALU with a bounded lock.
//
// Ports:
//   g_clk, g_reset                  clock, synchronous active-high reset
//   x_req_valid / x_req_ready       request handshake (ready = granted now)
//   x_req_op, x_req_pw              opcode and pack width
//   x_req_lhs, x_req_rhs            operands
//   a_flush                         kill A's pending/in-flight response
//   b_lock                          request B retention on the next cycle
//   x_rsp_valid / x_rsp_ready       response handshake
//   x_rsp_result, x_rsp_lt/eq       registered ALU result and flags
//   alu_valid, alu_flush, alu_ready ALU issue handshake
//   alu_pw, alu_op_*, alu_lhs/rhs   muxed, decoded ALU drive
//   alu_result, alu_lt, alu_eq      ALU outputs
//   alu_add_result                  ALU adder output (not used here)
// ----------------------------------------------------------------------------
module frv_alu_arb #(
    parameter int XLEN       = 32,
    parameter int PW         = 2,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            a_req_valid,
    output logic            a_req_ready,
    input  logic [3:0]      a_req_op,
    input  logic [PW:0]     a_req_pw,
    input  logic [XLEN-1:0] a_req_lhs,
    input  logic [XLEN-1:0] a_req_rhs,
    input  logic            a_flush,

    input  logic            b_req_valid,
    output logic            b_req_ready,
    input  logic [3:0]      b_req_op,
    input  logic [PW:0]     b_req_pw,
    input  logic [XLEN-1:0] b_req_lhs,
    input  logic [XLEN-1:0] b_req_rhs,
    input  logic            b_lock,

    output logic            a_rsp_valid,
    input  logic            a_rsp_ready,
    output logic [XLEN-1:0] a_rsp_result,
    output logic            a_rsp_lt,
    output logic            a_rsp_eq,

    output logic            b_rsp_valid,
    input  logic            b_rsp_ready,
    output logic [XLEN-1:0] b_rsp_result,
    output logic            b_rsp_lt,
    output logic            b_rsp_eq,

    output logic            alu_valid,
    output logic            alu_flush,
    input  logic            alu_ready,
    output logic [PW:0]     alu_pw,
    output logic            alu_op_pack,
    output logic            alu_op_add,
    output logic            alu_op_sub,
    output logic            alu_op_xor,
    output logic            alu_op_or,
    output logic            alu_op_and,
    output logic            alu_op_shf,
    output logic            alu_op_rot,
    output logic            alu_op_shf_left,
    output logic            alu_op_shf_arith,
    output logic            alu_op_cmp,
    output logic            alu_op_unsigned,
    output logic [XLEN-1:0] alu_lhs,
    output logic [XLEN-1:0] alu_rhs,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_add_result,
    input  logic            alu_lt,
    input  logic            alu_eq
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LOCK_TOP   = LW'(LOCK_MAX);

    logic            r_aRspValid;
    logic [XLEN-1:0] r_aRspResult;
    logic            r_aRspLt;
    logic            r_aRspEq;
    logic            r_bRspValid;
    logic [XLEN-1:0] r_bRspResult;
    logic            r_bRspLt;
    logic            r_bRspEq;
    logic [SW-1:0]   r_starveCnt;
    logic [LW-1:0]   r_lockCnt;
    logic            r_lockActive;

    logic            w_aElig;
    logic            w_bElig;
    logic            w_grantA;
    logic            w_grantB;
    logic            w_grant;
    logic [3:0]      w_op;
    logic [LW-1:0]   w_lockNext;
    logic            w_unused;

    // A slot is free when empty or being drained this cycle. Reset suppresses
    // any grant so an operation issued under reset is never half-accepted.
    assign w_aElig = a_req_valid && !a_flush && (!r_aRspValid || a_rsp_ready)
                     && alu_ready && !g_reset;
    assign w_bElig = b_req_valid && (!r_bRspValid || b_rsp_ready)
                     && alu_ready && !g_reset;

    // Winner selection: held lock, then forced B after starvation, then A.
    always_comb begin
        w_grantA = 1'b0;
        w_grantB = 1'b0;
        if (r_lockActive && w_bElig) begin
            w_grantB = 1'b1;
        end else if ((r_starveCnt == STARVE_TOP) && w_bElig) begin
            w_grantB = 1'b1;
        end else if (w_aElig) begin
            w_grantA = 1'b1;
        end else if (w_bElig) begin
            w_grantB = 1'b1;
        end
    end

    assign w_grant     = w_grantA || w_grantB;
    assign a_req_ready = w_grantA;
    assign b_req_ready = w_grantB;
    assign alu_valid   = w_grant;
    assign alu_flush   = 1'b0;
    assign w_lockNext  = r_lockCnt + LW'(1);
    assign w_unused    = ^alu_add_result;

    // Operand mux; everything is driven to zero when nobody is granted.
    always_comb begin
        w_op    = 4'd0;
        alu_pw  = '0;
        alu_lhs = '0;
        alu_rhs = '0;
        if (w_grantA) begin
            w_op    = a_req_op;
            alu_pw  = a_req_pw;
            alu_lhs = a_req_lhs;
            alu_rhs = a_req_rhs;
        end else if (w_grantB) begin
            w_op    = b_req_op;
            alu_pw  = b_req_pw;
            alu_lhs = b_req_lhs;
            alu_rhs = b_req_rhs;
        end
    end

    // Opcode decode; codes 13-15 leave every op line low.
    always_comb begin
        alu_op_pack      = 1'b0;
        alu_op_add       = 1'b0;
        alu_op_sub       = 1'b0;
        alu_op_xor       = 1'b0;
        alu_op_or        = 1'b0;
        alu_op_and       = 1'b0;
        alu_op_shf       = 1'b0;
        alu_op_rot       = 1'b0;
        alu_op_shf_left  = 1'b0;
        alu_op_shf_arith = 1'b0;
        alu_op_cmp       = 1'b0;
        alu_op_unsigned  = 1'b0;
        if (w_grant) begin
            case (w_op)
                4'd0:  alu_op_add = 1'b1;
                4'd1:  alu_op_sub = 1'b1;
                4'd2:  alu_op_xor = 1'b1;
                4'd3:  alu_op_or  = 1'b1;
                4'd4:  alu_op_and = 1'b1;
                4'd5:  begin alu_op_shf = 1'b1; alu_op_shf_left  = 1'b1; end
                4'd6:  alu_op_shf = 1'b1;
                4'd7:  begin alu_op_shf = 1'b1; alu_op_shf_arith = 1'b1; end
                4'd8:  begin alu_op_rot = 1'b1; alu_op_shf_left  = 1'b1; end
                4'd9:  alu_op_rot = 1'b1;
                4'd10: begin alu_op_sub = 1'b1; alu_op_cmp = 1'b1; end
                4'd11: begin
                    alu_op_sub      = 1'b1;
                    alu_op_cmp      = 1'b1;
                    alu_op_unsigned = 1'b1;
                end
                4'd12: alu_op_pack = 1'b1;
                default: ;
            endcase
        end
    end

    // Response registers, starvation counter and lock tracking. The lock
    // chain ends once the post-increment count reaches LOCK_MAX, which bounds
    // B to LOCK_MAX consecutive locked grants. With alu_ready low the lock
    // state is frozen; only the starvation counter keeps counting.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_aRspValid  <= 1'b0;
            r_aRspResult <= '0;
            r_aRspLt     <= 1'b0;
            r_aRspEq     <= 1'b0;
            r_bRspValid  <= 1'b0;
            r_bRspResult <= '0;
            r_bRspLt     <= 1'b0;
            r_bRspEq     <= 1'b0;
            r_starveCnt  <= '0;
            r_lockCnt    <= '0;
            r_lockActive <= 1'b0;
        end else begin
            if (w_grantA) begin
                r_aRspValid  <= 1'b1;
                r_aRspResult <= alu_result;
                r_aRspLt     <= alu_lt;
                r_aRspEq     <= alu_eq;
            end else if (a_flush || a_rsp_ready) begin
                r_aRspValid <= 1'b0;
            end

            if (w_grantB) begin
                r_bRspValid  <= 1'b1;
                r_bRspResult <= alu_result;
                r_bRspLt     <= alu_lt;
                r_bRspEq     <= alu_eq;
            end else if (b_rsp_ready) begin
                r_bRspValid <= 1'b0;
            end

            if (!b_req_valid || w_grantB) begin
                r_starveCnt <= '0;
            end else if (r_starveCnt != STARVE_TOP) begin
                r_starveCnt <= r_starveCnt + SW'(1);
            end

            if (alu_ready) begin
                if (w_grantB && b_lock) begin
                    if (r_lockCnt != LOCK_TOP) begin
                        r_lockCnt    <= w_lockNext;
                        r_lockActive <= (w_lockNext != LOCK_TOP);
                    end else begin
                        r_lockActive <= 1'b0;
                    end
                end else begin
                    r_lockCnt    <= '0;
                    r_lockActive <= 1'b0;
                end
            end
        end
    end

    assign a_rsp_valid  = r_aRspValid;
    assign a_rsp_result = r_aRspResult;
    assign a_rsp_lt     = r_aRspLt;
    assign a_rsp_eq     = r_aRspEq;
    assign b_rsp_valid  = r_bRspValid;
    assign b_rsp_result = r_bRspResult;
    assign b_rsp_lt     = r_bRspLt;
    assign b_rsp_eq     = r_bRspEq;

endmodule

// File: tb/tb_frv_alu_arb.sv
// ----------------------------------------------------------------------------
// tb_frv_alu_arb
//
// Directed bench for frv_alu_arb. A small behavioural ALU answers the decoded
// op lines; expected values below are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_frv_alu_arb;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        a_req_valid, a_req_ready, a_flush;
    logic [3:0]  a_req_op;
    logic [2:0]  a_req_pw;
    logic [31:0] a_req_lhs, a_req_rhs;
    logic        b_req_valid, b_req_ready, b_lock;
    logic [3:0]  b_req_op;
    logic [2:0]  b_req_pw;
    logic [31:0] b_req_lhs, b_req_rhs;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_lt, a_rsp_eq;
    logic [31:0] a_rsp_result;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_lt, b_rsp_eq;
    logic [31:0] b_rsp_result;
    logic        alu_valid, alu_flush, alu_ready;
    logic [2:0]  alu_pw;
    logic        alu_op_pack, alu_op_add, alu_op_sub, alu_op_xor, alu_op_or;
    logic        alu_op_and, alu_op_shf, alu_op_rot, alu_op_shf_left;
    logic        alu_op_shf_arith, alu_op_cmp, alu_op_unsigned;
    logic [31:0] alu_lhs, alu_rhs, alu_result, alu_add_result;
    logic        alu_lt, alu_eq;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] opLines;
    assign opLines = {alu_op_pack, alu_op_add, alu_op_sub, alu_op_xor,
                      alu_op_or, alu_op_and, alu_op_shf, alu_op_rot,
                      alu_op_shf_left, alu_op_shf_arith, alu_op_cmp,
                      alu_op_unsigned};

    frv_alu_arb dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_req_op(a_req_op), .a_req_pw(a_req_pw),
        .a_req_lhs(a_req_lhs), .a_req_rhs(a_req_rhs), .a_flush(a_flush),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_req_op(b_req_op), .b_req_pw(b_req_pw),
        .b_req_lhs(b_req_lhs), .b_req_rhs(b_req_rhs), .b_lock(b_lock),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .a_rsp_result(a_rsp_result), .a_rsp_lt(a_rsp_lt), .a_rsp_eq(a_rsp_eq),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .b_rsp_result(b_rsp_result), .b_rsp_lt(b_rsp_lt), .b_rsp_eq(b_rsp_eq),
        .alu_valid(alu_valid), .alu_flush(alu_flush), .alu_ready(alu_ready),
        .alu_pw(alu_pw),
        .alu_op_pack(alu_op_pack), .alu_op_add(alu_op_add),
        .alu_op_sub(alu_op_sub), .alu_op_xor(alu_op_xor),
        .alu_op_or(alu_op_or), .alu_op_and(alu_op_and),
        .alu_op_shf(alu_op_shf), .alu_op_rot(alu_op_rot),
        .alu_op_shf_left(alu_op_shf_left), .alu_op_shf_arith(alu_op_shf_arith),
        .alu_op_cmp(alu_op_cmp), .alu_op_unsigned(alu_op_unsigned),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_result(alu_result),
        .alu_add_result(alu_add_result), .alu_lt(alu_lt), .alu_eq(alu_eq)
    );

    always #5 g_clk = ~g_clk;

    // Behavioural ALU responding to the decoded op lines.
    always_comb begin
        alu_result     = 32'd0;
        alu_add_result = alu_lhs + alu_rhs;
        alu_eq         = (alu_lhs == alu_rhs);
        alu_lt         = alu_op_unsigned ? (alu_lhs < alu_rhs)
                                         : ($signed(alu_lhs) < $signed(alu_rhs));
        if (alu_op_add)                    alu_result = alu_lhs + alu_rhs;
        else if (alu_op_sub && alu_op_cmp) alu_result = {31'd0, alu_lt};
        else if (alu_op_sub)               alu_result = alu_lhs - alu_rhs;
        else if (alu_op_xor)               alu_result = alu_lhs ^ alu_rhs;
        else if (alu_op_or)                alu_result = alu_lhs | alu_rhs;
        else if (alu_op_and)               alu_result = alu_lhs & alu_rhs;
        else if (alu_op_shf) begin
            if (alu_op_shf_left)       alu_result = alu_lhs << alu_rhs[4:0];
            else if (alu_op_shf_arith) alu_result = $signed(alu_lhs) >>> alu_rhs[4:0];
            else                       alu_result = alu_lhs >> alu_rhs[4:0];
        end else if (alu_op_rot) begin
            if (alu_op_shf_left)
                alu_result = (alu_lhs << alu_rhs[4:0]) | (alu_lhs >> (6'd32 - {1'b0, alu_rhs[4:0]}));
            else
                alu_result = (alu_lhs >> alu_rhs[4:0]) | (alu_lhs << (6'd32 - {1'b0, alu_rhs[4:0]}));
        end else if (alu_op_pack)          alu_result = {alu_rhs[15:0], alu_lhs[15:0]};
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives both request ports, then lets the combinational paths settle.
    task automatic applyStimulus(input logic aV, input logic [3:0] aOp,
                                 input logic [31:0] aL, input logic [31:0] aR,
                                 input logic bV, input logic [3:0] bOp,
                                 input logic [31:0] bL, input logic [31:0] bR);
        a_req_valid = aV; a_req_op = aOp; a_req_lhs = aL; a_req_rhs = aR;
        b_req_valid = bV; b_req_op = bOp; b_req_lhs = bL; b_req_rhs = bR;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_reset = 1'b1; a_flush = 1'b0; b_lock = 1'b0; alu_ready = 1'b1;
        a_req_pw = 3'd0; b_req_pw = 3'd0;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        g_reset = 1'b0;
        #2;
        checkOutput("rst_a_valid", a_rsp_valid, 0);
        checkOutput("rst_b_valid", b_rsp_valid, 0);
        checkOutput("rst_a_result", a_rsp_result, 0);
        checkOutput("idle_alu_valid", alu_valid, 0);
        checkOutput("idle_alu_lhs", alu_lhs, 0);

        // A alone: ADD 5+7, response held while not consumed.
        a_req_pw = 3'd2;
        applyStimulus(1, 0, 5, 7, 0, 0, 0, 0);
        checkOutput("s1_a_ready", a_req_ready, 1);
        checkOutput("s1_ops", opLines, 12'h400);
        checkOutput("s1_pw", alu_pw, 3'd2);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s1_valid", a_rsp_valid, 1);
        checkOutput("s1_result", a_rsp_result, 32'd12);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput("s1_hold_valid", a_rsp_valid, 1);
            checkOutput("s1_hold_result", a_rsp_result, 32'd12);
        end
        a_rsp_ready = 1'b1;
        nextCycle();
        checkOutput("s1_consumed", a_rsp_valid, 0);

        // Both valid: A four times, then B forced by starvation.
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 10, 3, 1, 11, 1, 32'hFFFF_FFFF);
            checkOutput("s2_a_ready", a_req_ready, 1);
            checkOutput("s2_b_ready", b_req_ready, 0);
            nextCycle();
            checkOutput("s2_a_result", a_rsp_result, 32'd7);
        end
        #2;
        checkOutput("s2_b_forced", b_req_ready, 1);
        checkOutput("s2_a_refused", a_req_ready, 0);
        checkOutput("s2_sltu_ops", opLines, 12'h203);
        nextCycle();
        #2;
        checkOutput("s2_b_valid", b_rsp_valid, 1);
        checkOutput("s2_b_result", b_rsp_result, 32'd1);
        checkOutput("s2_b_lt", b_rsp_lt, 1);
        checkOutput("s2_a_resumes", a_req_ready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // B locked for ten requests while A waits: eight B grants, then A.
        b_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i != 0, 0, 3, 4, 1, 0, 1, 1);
            checkOutput("s3_b_locked", b_req_ready, 1);
            checkOutput("s3_a_held", a_req_ready, 0);
            nextCycle();
            if (i == 0) checkOutput("s3_b_result", b_rsp_result, 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 3, 4, 1, 0, 1, 1);
            checkOutput("s3_a_after_lock", a_req_ready, 1);
            checkOutput("s3_b_after_lock", b_req_ready, 0);
            nextCycle();
        end
        checkOutput("s3_a_result", a_rsp_result, 32'd7);
        b_lock = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // Flush: A granted, then flushed while B competes.
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        applyStimulus(1, 0, 2, 3, 1, 2, 32'hF0, 32'hFF);
        checkOutput("s4_a_ready", a_req_ready, 1);
        nextCycle();
        checkOutput("s4_a_result", a_rsp_result, 32'd5);
        a_flush = 1'b1;
        #2;
        checkOutput("s4_flush_blocks_a", a_req_ready, 0);
        checkOutput("s4_b_granted", b_req_ready, 1);
        nextCycle();
        a_flush = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s4_a_dropped", a_rsp_valid, 0);
        checkOutput("s4_b_valid", b_rsp_valid, 1);
        checkOutput("s4_b_result", b_rsp_result, 32'h0F);
        a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        nextCycle();

        // Decode: alu_ready low, SRA, ROL, SLT, opcode 14.
        alu_ready = 1'b0;
        applyStimulus(1, 7, 32'h8000_0000, 4, 0, 0, 0, 0);
        checkOutput("s5_not_ready_grant", a_req_ready, 0);
        checkOutput("s5_not_ready_valid", alu_valid, 0);
        alu_ready = 1'b1;
        #2;
        checkOutput("s5_sra_ops", opLines, 12'h024);
        checkOutput("s5_sra_lhs", alu_lhs, 32'h8000_0000);
        nextCycle();
        applyStimulus(1, 8, 32'h8000_0001, 1, 0, 0, 0, 0);
        checkOutput("s5_sra_result", a_rsp_result, 32'hF800_0000);
        checkOutput("s5_rol_ops", opLines, 12'h018);
        nextCycle();
        applyStimulus(1, 10, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        checkOutput("s5_rol_result", a_rsp_result, 32'h0000_0003);
        checkOutput("s5_slt_ops", opLines, 12'h202);
        nextCycle();
        applyStimulus(1, 14, 32'h1234, 32'h5678, 0, 0, 0, 0);
        checkOutput("s5_slt_result", a_rsp_result, 32'd1);
        checkOutput("s5_op14_ops", opLines, 12'h000);
        checkOutput("s5_op14_alu_valid", alu_valid, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s5_op14_valid", a_rsp_valid, 1);
        checkOutput("s5_op14_result", a_rsp_result, 32'd0);
        nextCycle();

        // Reset after a B grant, and reset during a would-be B grant.
        b_rsp_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 0, 4, 4);
        checkOutput("s6_b_ready", b_req_ready, 1);
        nextCycle();
        checkOutput("s6_b_result", b_rsp_result, 32'd8);
        g_reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 0, 4, 4);
        nextCycle();
        checkOutput("s6_rst_b_valid", b_rsp_valid, 0);
        checkOutput("s6_rst_b_data", b_rsp_result, 0);
        nextCycle();
        checkOutput("s6_rst_inflight", b_rsp_valid, 0);
        g_reset = 1'b0;
        applyStimulus(1, 0, 1, 2, 0, 0, 0, 0);
        checkOutput("s6_post_a_ready", a_req_ready, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s6_post_a_result", a_rsp_result, 32'd3);
        checkOutput("s6_alu_flush", alu_flush, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frv_alu_arb.md
Name: frv_alu_arb

Overview:
- Shares the single execute-stage ALU between two requesters: port A (pipeline execute, normal priority owner) and port B (auxiliary multi-cycle unit, e.g. a crypto or bitmanip sequencer).
- Arbitrates one operation per cycle and decodes a compact opcode into the ALU one-hot op lines.
- Captures each ALU result into a per-requester response register, presented one cycle after grant.
- Provides starvation protection and a bounded lock for B.

Parameters:
- XLEN, 32, datapath width (XL = XLEN-1).
- PW, 2, MSB index of the pack-width field.
- STARVE_MAX, 4, consecutive cycles B may be refused before it is forced to win.
- LOCK_MAX, 8, maximum consecutive locked B grants.

Ports:
- g_clk  input  1  global clock.
- g_reset  input  1  synchronous active-high reset.
- a_req_valid / b_req_valid  input  1  request present.
- a_req_ready / b_req_ready  output  1  request granted this cycle.
- a_req_op / b_req_op  input  4  opcode (see Behaviour).
- a_req_pw / b_req_pw  input  PW+1  pack width.
- a_req_lhs, a_req_rhs / b_req_lhs, b_req_rhs  input  XLEN  operands.
- a_flush  input  1  kill A's pending and in-flight response.
- b_lock  input  1  sampled with a B grant; request B retention next cycle.
- a_rsp_valid / b_rsp_valid  output  1  response held until ready.
- a_rsp_ready / b_rsp_ready  input  1  response consumed.
- a_rsp_result / b_rsp_result  output  XLEN  ALU result.
- a_rsp_lt, a_rsp_eq / b_rsp_lt, b_rsp_eq  output  1  compare flags.
- alu_valid  output  1  a grant is issued this cycle.
- alu_flush  output  1  tied 0.
- alu_ready  input  1  ALU accepts; a grant requires alu_ready.
- alu_pw  output  PW+1  muxed pack width.
- alu_op_{pack,add,sub,xor,or,and,shf,rot,shf_left,shf_arith,cmp,unsigned}  output  1 each  decoded op lines.
- alu_lhs, alu_rhs  output  XLEN  muxed operands.
- alu_result  input  XLEN  ALU result.
- alu_add_result  input  XLEN  ALU adder result; unused.
- alu_lt, alu_eq  input  1  ALU compare flags.

Behaviour:
- Opcode decode:
  - 0 ADD=add; 1 SUB=sub; 2 XOR; 3 OR; 4 AND.
  - 5 SLL=shf+shf_left; 6 SRL=shf; 7 SRA=shf+shf_arith.
  - 8 ROL=rot+shf_left; 9 ROR=rot.
  - 10 SLT=sub+cmp; 11 SLTU=sub+cmp+unsigned; 12 PACK=pack.
  - 13-15: all op lines 0; the response is still returned (result 0 from ALU).
- ALU drive is combinational from the granted port. With no grant, operands and op lines are driven 0.
- Slot free (per port): the response is not valid, or is valid with rsp_ready high this cycle. A port is eligible when req_valid is high, its slot is free and alu_ready is high.
- Winner selection, in priority order:
  1. lock_active (previous cycle granted B with b_lock=1 and lock_cnt < LOCK_MAX) and B eligible -> B.
  2. starve_cnt == STARVE_MAX and B eligible -> B.
  3. A eligible -> A.
  4. B eligible -> B.
- Grant: x_req_ready = 1 for the winner only. At the next edge, x_rsp_valid=1 and result/lt/eq are registered from the ALU.
- Latency: exactly 1 cycle from grant to rsp_valid.
- Back-to-back grants to the same port are allowed when its slot drains in the same cycle.
- Response hold: x_rsp_valid and the data are held stable until x_rsp_ready. A consume with no new grant clears valid.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when b_req_valid=1 and B is not granted.
  - Clears on a B grant or when b_req_valid=0.
- lock_cnt:
  - Increments on each consecutive locked B grant.
  - Clears on any non-B grant, on an idle cycle, or when b_lock=0.
  - At LOCK_MAX the lock is ignored and normal priority resumes.
- a_flush:
  - Clears a_rsp_valid at the next edge.
  - Blocks A from the grant in the same cycle.
  - Does not affect B, the counters or the lock.
- Reset (sync, g_reset=1): all rsp_valid=0, rsp data=0, starve_cnt=0, lock_cnt=0, lock_active=0. Reset takes priority over a grant in the same cycle; an in-flight result is discarded.
- alu_ready=0: no grant and no counter change, except starve_cnt, which still counts.

Test Plan:
- A op=0, lhs=5, rhs=7, pw=PW_32 alone -> a_req_ready same cycle, a_rsp_result=12 one cycle later, held while a_rsp_ready=0 for 3 cycles.
- A and B both valid continuously (A SUB 10-3, B SLTU 1 vs 0xFFFFFFFF) -> A granted 4 cycles (results 7), B forced on the 5th with b_rsp_result=1, lt=1, then A resumes.
- B with b_lock=1 for 10 ops while A valid -> exactly 8 consecutive B grants, then A granted, starve_cnt=0 after B grants.
- A granted, a_flush next cycle with a_rsp_ready=0 -> a_rsp_valid drops, no A grant that cycle, B unaffected.
- SRA lhs=0x80000000, shamt=4 -> alu_op_shf=1, alu_op_shf_arith=1, others 0; opcode 14 -> all op lines 0, rsp_valid still 1.
- g_reset asserted in the cycle after a B grant -> b_rsp_valid stays 0, counters 0; first post-reset A request granted normally.
